// File: rtl/rs_muldiv_multi.sv
// Multi-entry reservation station feeding one iterative-latency mul/div unit.
// Operands are renamed to producer tags and captured from the CDB.
module rs_muldiv_multi #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned ENTRIES  = 4,
  parameter int unsigned TAG_BASE = 1,
  parameter int unsigned MUL_LAT  = 10,
  parameter int unsigned DIV_LAT  = 40
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  logic [2:0]                     issue_op,
  input  logic [DATA_W-1:0]              issue_vj,
  input  logic [DATA_W-1:0]              issue_vk,
  input  logic [TAG_W-1:0]               issue_qj,
  input  logic [TAG_W-1:0]               issue_qk,
  output logic [TAG_W-1:0]               issue_tag,
  input  logic                           cdb_valid,
  input  logic [TAG_W-1:0]               cdb_tag,
  input  logic [DATA_W-1:0]              cdb_data,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [TAG_W-1:0]               res_tag,
  output logic [DATA_W-1:0]              res_data,
  output logic [$clog2(ENTRIES+1)-1:0]   busy_cnt
);

  localparam int unsigned CNT_W   = $clog2(ENTRIES + 1);
  localparam int unsigned IDX_W   = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned TMR_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXE, S_DONE} state_e;
  typedef enum logic [2:0] {
    OP_MUL   = 3'd2,
    OP_MULHU = 3'd3,
    OP_DIVU  = 3'd4,
    OP_REMU  = 3'd5
  } op_e;

  // Entry storage
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] disp_q;
  logic [2:0]         op_q [ENTRIES];
  logic [DATA_W-1:0]  vj_q [ENTRIES];
  logic [DATA_W-1:0]  vk_q [ENTRIES];
  logic [TAG_W-1:0]   qj_q [ENTRIES];
  logic [TAG_W-1:0]   qk_q [ENTRIES];

  // Unit state
  state_e             state_q;
  logic [TMR_W-1:0]   tmr_q;
  logic [DATA_W-1:0]  u_res_q;
  logic [TAG_W-1:0]   u_tag_q;
  logic [IDX_W-1:0]   u_idx_q;
  logic               res_valid_q;
  logic [TAG_W-1:0]   res_tag_q;
  logic [DATA_W-1:0]  res_data_q;

  logic [ENTRIES-1:0] rdy_vec;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W-1:0]   rdy_idx;
  logic [CNT_W-1:0]   occ_cnt;
  logic               issue_fire;
  logic               fwd_j;
  logic               fwd_k;

  logic [DATA_W-1:0]   disp_a;
  logic [DATA_W-1:0]   disp_b;
  logic [2:0]          disp_op;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   disp_res;
  logic [TMR_W-1:0]    disp_tmr;

  always_comb begin
    rdy_vec = '0;
    occ_cnt = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      rdy_vec[i] = valid_q[i] && !disp_q[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
      occ_cnt    = occ_cnt + CNT_W'(valid_q[i]);
    end
  end

  // Scan from the top so the lowest matching index is the last one written
  always_comb begin
    free_idx = '0;
    rdy_idx  = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (!valid_q[ENTRIES-1-i]) free_idx = IDX_W'(ENTRIES - 1 - i);
      if (rdy_vec[ENTRIES-1-i])  rdy_idx  = IDX_W'(ENTRIES - 1 - i);
    end
  end

  assign busy_cnt    = occ_cnt;
  assign issue_ready = (occ_cnt < CNT_W'(ENTRIES));
  assign issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(free_idx);
  assign issue_fire  = issue_valid && issue_ready;
  assign fwd_j       = cdb_valid && (issue_qj != '0) && (cdb_tag == issue_qj);
  assign fwd_k       = cdb_valid && (issue_qk != '0) && (cdb_tag == issue_qk);

  // Result is computed at dispatch and released once the latency timer expires
  assign disp_a  = vj_q[rdy_idx];
  assign disp_b  = vk_q[rdy_idx];
  assign disp_op = op_q[rdy_idx];
  assign prod    = {{DATA_W{1'b0}}, disp_a} * {{DATA_W{1'b0}}, disp_b};

  always_comb begin
    disp_res = prod[DATA_W-1:0];
    disp_tmr = TMR_W'(MUL_LAT - 1);
    case (disp_op)
      OP_MULHU: disp_res = prod[2*DATA_W-1:DATA_W];
      OP_DIVU: begin
        disp_tmr = TMR_W'(DIV_LAT - 1);
        disp_res = (disp_b == '0) ? '1 : disp_a / disp_b;
      end
      OP_REMU: begin
        disp_tmr = TMR_W'(DIV_LAT - 1);
        disp_res = (disp_b == '0) ? disp_a : disp_a % disp_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      valid_q     <= '0;
      disp_q      <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        op_q[i] <= '0;
        vj_q[i] <= '0;
        vk_q[i] <= '0;
        qj_q[i] <= '0;
        qk_q[i] <= '0;
      end
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      u_res_q     <= '0;
      u_tag_q     <= '0;
      u_idx_q     <= '0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_data_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        if (valid_q[i] && cdb_valid) begin
          if ((qj_q[i] != '0) && (qj_q[i] == cdb_tag)) begin
            vj_q[i] <= cdb_data;
            qj_q[i] <= '0;
          end
          if ((qk_q[i] != '0) && (qk_q[i] == cdb_tag)) begin
            vk_q[i] <= cdb_data;
            qk_q[i] <= '0;
          end
        end
      end

      if (issue_fire) begin
        valid_q[free_idx] <= 1'b1;
        disp_q[free_idx]  <= 1'b0;
        op_q[free_idx]    <= issue_op;
        vj_q[free_idx]    <= fwd_j ? cdb_data : issue_vj;
        qj_q[free_idx]    <= fwd_j ? '0 : issue_qj;
        vk_q[free_idx]    <= fwd_k ? cdb_data : issue_vk;
        qk_q[free_idx]    <= fwd_k ? '0 : issue_qk;
      end

      case (state_q)
        S_IDLE: begin
          if (|rdy_vec) begin
            disp_q[rdy_idx] <= 1'b1;
            u_res_q         <= disp_res;
            u_tag_q         <= TAG_W'(TAG_BASE) + TAG_W'(rdy_idx);
            u_idx_q         <= rdy_idx;
            tmr_q           <= disp_tmr;
            state_q         <= S_EXE;
          end
        end
        S_EXE: begin
          if (tmr_q == '0) begin
            res_valid_q <= 1'b1;
            res_tag_q   <= u_tag_q;
            res_data_q  <= u_res_q;
            state_q     <= S_DONE;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end
        S_DONE: begin
          if (res_ready) begin
            res_valid_q      <= 1'b0;
            valid_q[u_idx_q] <= 1'b0;
            disp_q[u_idx_q]  <= 1'b0;
            state_q          <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_tag   = res_tag_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_rs_muldiv_multi.sv
// Scoreboard bench for rs_muldiv_multi: default instance plus a small-latency
// 8-entry instance sharing the same stimulus.
module tb_rs_muldiv_multi;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        issue_valid;
  logic [2:0]  issue_op;
  logic [31:0] issue_vj, issue_vk;
  logic [3:0]  issue_qj, issue_qk;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        res_ready;

  logic        issue_ready, res_valid;
  logic [3:0]  issue_tag, res_tag;
  logic [31:0] res_data;
  logic [2:0]  busy_cnt;

  logic        b_issue_ready, b_res_valid;
  logic [3:0]  b_issue_tag, b_res_tag;
  logic [31:0] b_res_data;
  logic [3:0]  b_busy_cnt;

  rs_muldiv_multi #(.DATA_W(32), .TAG_W(4), .ENTRIES(4), .TAG_BASE(1),
                    .MUL_LAT(10), .DIV_LAT(40)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_tag(issue_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_data(res_data),
    .busy_cnt(busy_cnt)
  );

  rs_muldiv_multi #(.DATA_W(32), .TAG_W(4), .ENTRIES(8), .TAG_BASE(8),
                    .MUL_LAT(3), .DIV_LAT(40)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(b_issue_ready), .issue_op(issue_op),
    .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj(issue_qj), .issue_qk(issue_qk),
    .issue_tag(b_issue_tag), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .res_valid(b_res_valid), .res_ready(res_ready), .res_tag(b_res_tag), .res_data(b_res_data),
    .busy_cnt(b_busy_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    int          rise;
  } exp_t;
  exp_t sb[$];

  task automatic expect_res(input logic [3:0] tag, input logic [31:0] data, input int rise);
    exp_t e;
    e.tag = tag; e.data = data; e.rise = rise;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: records the rise cycle, compares on handshake
  bit   seen = 1'b0;
  int   rise_cyc = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid && !seen) begin
        seen     = 1'b1;
        rise_cyc = cyc;
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          check_eq("unexpected_res", res_valid, 0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("res_tag", res_tag, mon_e.tag);
          check_eq("res_data", res_data, mon_e.data);
          check_eq("res_rise_cycle", rise_cyc, mon_e.rise);
        end
        seen = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [2:0] op, input logic [31:0] vj, input logic [31:0] vk,
                          input logic [3:0] qj, input logic [3:0] qk,
                          input logic [3:0] exp_tag, output int ed);
    check_eq("issue_ready", issue_ready, 1);
    check_eq("issue_tag", issue_tag, exp_tag);
    issue_valid = 1'b1;
    issue_op = op; issue_vj = vj; issue_vk = vk; issue_qj = qj; issue_qk = qk;
    ed = cyc + 1;
    tick();
    issue_valid = 1'b0;
    issue_qj = '0; issue_qk = '0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check_eq("drain_timeout", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ed, e0, e1, e2, c, n;
    bit saw;
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_op = '0;
    issue_vj = '0; issue_vk = '0; issue_qj = '0; issue_qk = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; res_ready = 1'b1;
    repeat (3) tick();

    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_res_tag", res_tag, 0);
    check_eq("rst_res_data", res_data, 0);
    check_eq("rst_busy", busy_cnt, 0);
    check_eq("rst_issue_ready", issue_ready, 1);
    check_eq("rst_issue_tag", issue_tag, 1);
    check_eq("rst_b_issue_tag", b_issue_tag, 8);
    rst_n = 1'b1;
    tick();

    // Basic MUL
    do_issue(3'd2, 32'd6, 32'd7, 4'd0, 4'd0, 4'd1, ed);
    check_eq("s1_busy", busy_cnt, 1);
    check_eq("s1_no_early_res", res_valid, 0);
    expect_res(4'd1, 32'd42, ed + 11);
    wait_drain(40);
    check_eq("s1_busy_free", busy_cnt, 0);

    // DIVU by zero held under backpressure, then REMU by zero
    res_ready = 1'b0;
    do_issue(3'd4, 32'd100, 32'd0, 4'd0, 4'd0, 4'd1, ed);
    expect_res(4'd1, 32'hFFFF_FFFF, ed + 41);
    n = 0;
    while (!res_valid && n < 60) begin
      tick();
      n++;
    end
    check_eq("div0_valid", res_valid, 1);
    repeat (5) begin
      tick();
      check_eq("hold_valid", res_valid, 1);
      check_eq("hold_data", res_data, 32'hFFFF_FFFF);
      check_eq("hold_tag", res_tag, 1);
    end
    res_ready = 1'b1;
    wait_drain(5);
    do_issue(3'd5, 32'd100, 32'd0, 4'd0, 4'd0, 4'd1, ed);
    expect_res(4'd1, 32'd100, ed + 41);
    wait_drain(60);

    // Fill all entries waiting on tag 9, then wake them with one broadcast
    for (int i = 0; i < 4; i++) begin
      do_issue(3'd2, 32'd0, 32'(i + 1), 4'd9, 4'd0, 4'(i + 1), ed);
    end
    check_eq("full_issue_ready", issue_ready, 0);
    check_eq("full_busy", busy_cnt, 4);
    issue_valid = 1'b1;
    issue_op = 3'd2; issue_vj = 32'd5; issue_vk = 32'd5;
    tick();
    issue_valid = 1'b0;
    check_eq("full_ignored_busy", busy_cnt, 4);
    check_eq("full_no_dispatch", res_valid, 0);
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 32'd3;
    c = cyc + 1;
    tick();
    cdb_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_res(4'(i + 1), 32'(3 * (i + 1)), c + 11 + 12 * i);
    end
    wait_drain(80);
    check_eq("full_busy_free", busy_cnt, 0);

    // Issue-cycle forwarding on j
    cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'h10;
    do_issue(3'd2, 32'hDEAD, 32'd2, 4'd5, 4'd0, 4'd1, ed);
    cdb_valid = 1'b0;
    expect_res(4'd1, 32'h20, ed + 11);
    wait_drain(30);

    // Normal DIVU, wrapping MUL, REMU with k captured by snoop
    do_issue(3'd4, 32'd100, 32'd7, 4'd0, 4'd0, 4'd1, e0);
    do_issue(3'd2, 32'hFFFF_FFFF, 32'd2, 4'd0, 4'd0, 4'd2, e1);
    do_issue(3'd5, 32'd100, 32'd0, 4'd0, 4'd7, 4'd3, e2);
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 32'd30;
    tick();
    cdb_valid = 1'b0;
    expect_res(4'd1, 32'd14, e0 + 41);
    expect_res(4'd2, 32'hFFFF_FFFE, e0 + 53);
    expect_res(4'd3, 32'd10, e0 + 95);
    wait_drain(120);

    // Flush mid-execution
    do_issue(3'd2, 32'd1, 32'd1, 4'd0, 4'd0, 4'd1, e0);
    do_issue(3'd2, 32'd1, 32'd1, 4'd0, 4'd0, 4'd2, e1);
    do_issue(3'd2, 32'd1, 32'd1, 4'd0, 4'd0, 4'd3, e2);
    repeat (3) tick();
    check_eq("pre_flush_busy", busy_cnt, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("flush_busy", busy_cnt, 0);
    check_eq("flush_issue_ready", issue_ready, 1);
    check_eq("flush_res_valid", res_valid, 0);
    check_eq("flush_res_tag", res_tag, 0);
    check_eq("flush_res_data", res_data, 0);
    saw = 1'b0;
    repeat (20) begin
      tick();
      if (res_valid) saw = 1'b1;
    end
    check_eq("flush_no_res", saw, 0);

    // Second configuration: MULHU on the 8-entry, MUL_LAT=3 instance
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("b_rst_busy", b_busy_cnt, 0);
    check_eq("b_issue_tag", b_issue_tag, 8);
    do_issue(3'd3, 32'hFFFF_FFFF, 32'd2, 4'd0, 4'd0, 4'd1, ed);
    expect_res(4'd1, 32'd1, ed + 11);
    n = 0;
    while (!b_res_valid && n < 10) begin
      tick();
      n++;
    end
    check_eq("b_rise_cycle", cyc, ed + 4);
    check_eq("b_res_tag", b_res_tag, 8);
    check_eq("b_res_data", b_res_data, 1);
    wait_drain(30);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/rs_muldiv_multi.md
Name: rs_muldiv_multi

Overview:
- Parametrised multi-entry reservation station for the multiply/divide unit of the Tomasulo core.
- Holds up to ENTRIES issued instructions and renames operands to producer tags.
- Snoops the CDB to capture pending operands, then dispatches the lowest-index ready entry to one internal iterative-latency mul/div unit.
- Presents the result on a valid/ready port toward the CDB arbiter.

Parameters:
- DATA_W, 32: operand/result width.
- TAG_W, 4: rename tag width. Tag 0 means "value present".
- ENTRIES, 4: number of RS entries, 1..8.
- TAG_BASE, 1: tag of entry i is TAG_BASE+i. TAG_BASE+ENTRIES-1 must be < 2^TAG_W, and TAG_BASE ≥ 1.
- MUL_LAT, 10: cycles from dispatch to result for MUL.
- DIV_LAT, 40: cycles from dispatch to result for DIV/REM.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous clear of all entries and the unit (branch mispredict).
- issue_valid  in  1  issue request.
- issue_ready  out  1  at least one free entry.
- issue_op  in  3  2=MUL (low product), 3=MULHU (high unsigned product), 4=DIVU, 5=REMU; other codes treated as MUL.
- issue_vj, issue_vk  in  DATA_W  operand values, used when the matching Q is 0.
- issue_qj, issue_qk  in  TAG_W  producer tags, 0 = ready.
- issue_tag  out  TAG_W  tag that the entry receiving the current issue will take (combinational, valid when issue_ready).
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  DATA_W  broadcast value.
- res_valid  out  1  result available.
- res_ready  in  1  CDB arbiter accepts result.
- res_tag  out  TAG_W  tag of the producing entry.
- res_data  out  DATA_W  result.
- busy_cnt  out  $clog2(ENTRIES+1)  number of occupied entries.

Behaviour:
- Reset (rst_n=0 at posedge): all entries invalid, Q fields 0, unit IDLE, timer 0. Outputs: res_valid=0, res_tag=0, res_data=0, busy_cnt=0, issue_ready=1. Flush has identical effect. Reset and flush override every other event in the same cycle, including mid-execution; any in-flight result is discarded.
- Entry fields: valid, dispatched, op, Vj, Vk, Qj, Qk.
- Issue:
  - On issue_valid && issue_ready, the lowest-index free entry is written at the posedge.
  - issue_valid while !issue_ready is ignored; no state changes.
  - issue_tag = TAG_BASE + index of the lowest free entry.
- Issue-cycle forwarding: if cdb_valid && cdb_tag==issue_qj && issue_qj!=0, the entry stores Vj=cdb_data, Qj=0. Same rule applies to k independently.
- CDB snoop: each cycle, every valid entry with Qj==cdb_tag (Qj!=0) and cdb_valid captures Vj=cdb_data and clears Qj. Same rule for k. Both operands may capture in the same cycle.
- Ready: valid && !dispatched && Qj==0 && Qk==0, evaluated on registered state. A capture makes the entry ready the following cycle.
- Unit FSM:
  - IDLE → EXE: when any entry is ready, the lowest-index ready entry is dispatched. Operands, op, and tag are latched into the unit; the entry's dispatched bit is set; timer = LAT-1, where LAT is MUL_LAT for ops 2/3 and DIV_LAT for ops 4/5.
  - EXE: timer decrements each cycle. At timer==0 → DONE, with res_data and res_tag registered.
  - DONE: res_valid=1; res_tag/res_data held stable until res_ready. On res_valid && res_ready the entry is freed (valid=0) and the FSM returns to IDLE; the next dispatch happens in the following cycle at the earliest.
- Latency: dispatch at posedge t gives res_valid high from posedge t+LAT.
- Arithmetic:
  - MUL: low DATA_W bits of the unsigned 2·DATA_W product.
  - MULHU: high DATA_W bits of that product.
  - DIVU by 0 returns all ones. REMU by 0 returns the dividend.
  - The unit may compute combinationally at dispatch and delay; only the result timing is specified.
- Simultaneous events:
  - A free on res accept and an issue in the same cycle: the issue uses the pre-edge free set, so a just-freed entry becomes available next cycle.
  - A CDB broadcast and issue to an entry in the same cycle: the forwarding rule applies.
  - The unit's own result is not internally forwarded; dependents wait for it on the CDB.
- busy_cnt counts valid entries. issue_ready = busy_cnt < ENTRIES.

Test Plan:
- Reset, then issue MUL with vj=6, vk=7, q=0 at cycle 0 → issue_tag=1; dispatch at cycle 1; res_valid at cycle 11 with res_data=42, res_tag=1; res_ready=1 frees the entry and busy_cnt returns to 0.
- Issue DIVU 100/0 with res_ready held 0 → res_valid rises after 40 cycles with data=0xFFFFFFFF, held stable for 5 cycles; the REMU 100/0 variant returns 100.
- Fill 4 entries with qj=9 → issue_ready=0 and a 5th issue is ignored. A CDB broadcast of tag 9, data 3 makes all 4 ready; entries dispatch in order 1,2,3,4, each back-to-back after its accept.
- Issue with qj=5 while cdb_valid, cdb_tag=5, cdb_data=0x10 in the same cycle → entry stores Vj=0x10 and dispatches the next cycle.
- Assert flush mid-EXE with 3 entries busy → next cycle busy_cnt=0, res_valid never rises, issue_ready=1.
- Repeat the first scenario with ENTRIES=8, TAG_BASE=8, MUL_LAT=3, MULHU 0xFFFFFFFF×2 → res_tag=8 and res_data=1 at dispatch+3.
